rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Table-driven transaction sequencer for the RTC multiplexed address/data bus (AD select, CS, RD, WR strobes).
- Replaces fixed-sequence init machines. Walks N entries of {rd flag, address, data} from an external table (ROM or register file).
- Each entry runs an address phase then a data phase, write or read, with parametrised strobe and gap timing.
- Sits between the top-level control FSM and the RTC pads. One instance serves init, periodic time reads and user set-time writes.

Parameters:
DEPTH, 16, maximum table entries; IDX_W = clog2(DEPTH)
T_STB, 7, cycles each strobe is held asserted (>=1)
T_GAP, 7, cycles of idle bus after each strobe (>=1)
CNT_W, 4, phase counter width; must hold max(T_STB,T_GAP)

Ports:
clk_i  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle request to run entries 0..num_i-1
num_i  in  IDX_W+1  entry count, sampled with start_i
abort_i  in  1  terminate current sequence
idx_o  out  IDX_W  current table index
entry_i  in  17  {rd_flag[16], addr[15:8], data[7:0]} for idx_o, combinational table
bus_o  out  8  value driven onto AD bus
bus_oe  out  1  tristate enable for bus_o (1 = drive)
bus_i  in  8  AD bus read-back
ad_o  out  1  0 = address phase, 1 = data phase
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse, sequence completed
aborted_o  out  1  one-cycle pulse, sequence aborted
rd_data_o  out  8  last read value
rd_valid_o  out  1  one-cycle pulse with rd_data_o

Behaviour:
Reset values (asynchronous, while reset=0):
- cs_n=rd_n=wr_n=1; ad_o=0; bus_oe=0; bus_o=0.
- busy_o=done_o=aborted_o=rd_valid_o=0; rd_data_o=0; idx_o=0.
- FSM in IDLE.
- Reset asserted mid-strobe releases all strobes immediately.

FSM states: IDLE, ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP, FINISH.

IDLE:
- start_i=1 latches num_i.
- num_i=0: go to FINISH.
- Otherwise: idx_o=0, busy_o=1, go to ADDR_STB.
- start_i while busy_o=1 is ignored.

ADDR_STB (T_STB cycles):
- ad_o=0, bus_o=addr, bus_oe=1, cs_n=0, wr_n=0, rd_n=1.
- First strobe cycle is the cycle after start_i is sampled.

ADDR_GAP (T_GAP cycles):
- cs_n=rd_n=wr_n=1.
- bus_o holds addr with bus_oe=1.

DATA_STB (T_STB cycles), ad_o=1, cs_n=0:
- Write (rd_flag=0): bus_o=data, bus_oe=1, wr_n=0.
- Read (rd_flag=1): bus_oe=0, rd_n=0. bus_i is registered on the last strobe cycle into rd_data_o, with rd_valid_o pulsing the following cycle.

DATA_GAP (T_GAP cycles):
- Strobes high, bus_oe=0.
- On exit: if idx_o==num-1, go to FINISH. Otherwise idx_o+1 and go to ADDR_STB.

FINISH:
- One cycle: done_o=1, busy_o deasserts next cycle, go to IDLE.

Timing and boundaries:
- Entry length is exactly 2*(T_STB+T_GAP) cycles. Defaults give 28 cycles per entry.
- entry_i is sampled only at ADDR_STB entry and held internally for the whole entry; table changes mid-entry have no effect.
- abort_i in any non-IDLE state: next cycle strobes high, bus_oe=0, aborted_o=1, IDLE, no done_o.
- abort_i and start_i together in IDLE: start wins.
- num_i > DEPTH saturates to DEPTH.
- The phase counter restarts at 0 on every state change; no wrap inside a phase.
- No strobe overlaps a state transition: CS, RD and WR are never low across a gap.

Optional Feature:
Macro RTC_SEQ_READBACK_EN.
- Defined: after every write entry, the sequencer performs an extra read transaction (ADDR_STB..DATA_GAP, same address) and compares bus_i with the written data.
- On mismatch it sets a sticky output mismatch_o (reset 0, cleared on start_i) and latches err_idx_o (IDX_W) of the first failing entry.
- Entry time for write entries doubles.
- Undefined: no mismatch_o or err_idx_o ports; write entries take 2*(T_STB+T_GAP).

Test Plan:
1. Reset low mid ADDR_STB -> within the same cycle cs_n=wr_n=1, bus_oe=0; after release, IDLE with all outputs at reset values.
2. Write table {02:10, 02:00, 10:D2}, num_i=3, defaults:
   - Address and data strobes each last 7 cycles, separated by 7-cycle gaps.
   - bus_o shows 02/10/02/00/10/D2 in order.
   - done_o pulses at cycle 85 after start.
3. Read entry addr 21, bus model returns 3A -> rd_n low 7 cycles, bus_oe=0 during DATA_STB, rd_valid_o pulses once with rd_data_o=3A.
4. num_i=0 -> done_o pulses 1 cycle after start_i, no strobe activity; start_i while busy with num_i=3 -> ignored, sequence completes normally.
5. abort_i at entry 1 DATA_STB cycle 3 -> strobes high next cycle, aborted_o pulse, no done_o, idx_o not incremented; new start then completes.
6. RTC_SEQ_READBACK_EN with bus model corrupting entry 2 to 00 -> mismatch_o=1, err_idx_o=2, sequence still completes with done_o.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Table-driven address/data transaction sequencer for the multiplexed RTC bus.
// Define RTC_SEQ_READBACK_EN to add a verify read after every write entry (mismatch_o, err_idx_o).
module rtc_bus_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned T_STB = 7,
  parameter int unsigned T_GAP = 7,
  parameter int unsigned CNT_W = 4,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             start_i,
  input  logic [IDX_W:0]   num_i,
  input  logic             abort_i,
  output logic [IDX_W-1:0] idx_o,
  input  logic [16:0]      entry_i,
  output logic [7:0]       bus_o,
  output logic             bus_oe,
  input  logic [7:0]       bus_i,
  output logic             ad_o,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o
`ifdef RTC_SEQ_READBACK_EN
  ,
  output logic             mismatch_o,
  output logic [IDX_W-1:0] err_idx_o
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP, FINISH} state_e;
  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

`ifdef RTC_SEQ_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W:0]   num_q, num_d, num_sat;
  logic [IDX_W-1:0] idx_q, idx_d;
  entry_t           ent_q, ent_d;
  logic             last_q, last_d, rb_q, rb_d;
  logic [7:0]       bus_q, bus_d, rd_data_q, rd_data_d;
  logic             oe_q, oe_d, ad_q, ad_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d, rd_valid_q, rd_valid_d;
  logic             phase_end, rb_pending;
`ifdef RTC_SEQ_READBACK_EN
  logic             mismatch_q, mismatch_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
`endif

  assign num_sat    = (num_i > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_i;
  assign phase_end  = (state_q == ADDR_STB || state_q == DATA_STB) ? (cnt_q == CNT_W'(T_STB - 1))
                                                                   : (cnt_q == CNT_W'(T_GAP - 1));
  // A write entry still owes its verify read when readback is built in.
  assign rb_pending = RB_EN && !ent_q.rd && !rb_q;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    last_d     = last_q;
    rb_d       = rb_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    aborted_d  = 1'b0;
`ifdef RTC_SEQ_READBACK_EN
    mismatch_d = mismatch_q;
    err_idx_d  = err_idx_q;
`endif

    unique case (state_q)
      IDLE: if (start_i) begin
        num_d   = num_sat;
        state_d = (num_i == '0) ? FINISH : ADDR_STB;
`ifdef RTC_SEQ_READBACK_EN
        mismatch_d = 1'b0;
        err_idx_d  = '0;
`endif
      end
      ADDR_STB: if (phase_end) state_d = ADDR_GAP;
      ADDR_GAP: if (phase_end) state_d = DATA_STB;
      DATA_STB: if (phase_end) state_d = DATA_GAP;
      DATA_GAP: if (phase_end) begin
        if (rb_pending) begin
          state_d = ADDR_STB;
          rb_d    = 1'b1;
        end else if (last_q) begin
          state_d = FINISH;
        end else begin
          state_d = ADDR_STB;
          rb_d    = 1'b0;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_i && state_q != IDLE) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end
    if (state_d == IDLE || state_d == FINISH) rb_d = 1'b0;

    cnt_d = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + CNT_W'(1);

    // Fresh entry: snapshot the table row addressed by idx_o for the whole entry.
    if (state_d == ADDR_STB && state_q != ADDR_STB && !rb_d) begin
      ent_d  = entry_t'(entry_i);
      last_d = (({1'b0, idx_q} + (IDX_W+1)'(1)) == num_d);
    end

    // Index steps on the final gap cycle so the next row is ready when ADDR_STB starts.
    if (state_d == IDLE || state_d == FINISH) begin
      idx_d = '0;
    end else if (state_d == DATA_GAP && cnt_d == CNT_W'(T_GAP - 1) && !last_q && !rb_pending) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (state_q == DATA_STB && state_d == DATA_GAP) begin
      if (ent_q.rd) begin
        rd_data_d  = bus_i;
        rd_valid_d = 1'b1;
      end
`ifdef RTC_SEQ_READBACK_EN
      if (rb_q && bus_i != ent_q.data && !mismatch_q) begin
        mismatch_d = 1'b1;
        err_idx_d  = idx_q;
      end
`endif
    end

    bus_d  = '0;
    oe_d   = 1'b0;
    ad_d   = 1'b0;
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    case (state_d)
      ADDR_STB: begin
        bus_d  = ent_d.addr;
        oe_d   = 1'b1;
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
      end
      ADDR_GAP: begin
        bus_d = ent_d.addr;
        oe_d  = 1'b1;
      end
      DATA_STB: begin
        ad_d   = 1'b1;
        cs_n_d = 1'b0;
        if (ent_d.rd || rb_d) begin
          rd_n_d = 1'b0;
        end else begin
          bus_d  = ent_d.data;
          oe_d   = 1'b1;
          wr_n_d = 1'b0;
        end
      end
      DATA_GAP: ad_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      ent_q      <= '0;
      last_q     <= 1'b0;
      rb_q       <= 1'b0;
      bus_q      <= '0;
      oe_q       <= 1'b0;
      ad_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef RTC_SEQ_READBACK_EN
      mismatch_q <= 1'b0;
      err_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      last_q     <= last_d;
      rb_q       <= rb_d;
      bus_q      <= bus_d;
      oe_q       <= oe_d;
      ad_q       <= ad_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef RTC_SEQ_READBACK_EN
      mismatch_q <= mismatch_d;
      err_idx_q  <= err_idx_d;
`endif
    end
  end

  assign idx_o      = idx_q;
  assign bus_o      = bus_q;
  assign bus_oe     = oe_q;
  assign ad_o       = ad_q;
  assign cs_n       = cs_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`ifdef RTC_SEQ_READBACK_EN
  assign mismatch_o = mismatch_q;
  assign err_idx_o  = err_idx_q;
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: vector table for full write/read sequences plus
// hand-written reset, empty-run, busy-start, abort and readback sequences.
module tb_rtc_bus_sequencer;
  localparam int unsigned IDX_W = 4;
`ifdef RTC_SEQ_READBACK_EN
  localparam int WR_ENTRY = 56;
`else
  localparam int WR_ENTRY = 28;
`endif

  logic             clk = 1'b0;
  logic             rst_n, start_i, abort_i;
  logic [IDX_W:0]   num_i;
  logic [IDX_W-1:0] idx_o;
  logic [16:0]      entry_i;
  logic [7:0]       bus_o, bus_i, rd_data_o;
  logic             bus_oe, ad_o, cs_n, rd_n, wr_n, busy_o, done_o, aborted_o, rd_valid_o;
`ifdef RTC_SEQ_READBACK_EN
  logic             mismatch_o;
  logic [IDX_W-1:0] err_idx_o;
`endif
  logic [16:0]      tbl [16];
  logic             rb_mode;

  assign entry_i = tbl[idx_o];
  assign bus_i   = rd_n ? 8'hFF : (rb_mode ? ((idx_o == 4'd2) ? 8'h00 : tbl[idx_o][7:0]) : 8'h3A);

  rtc_bus_sequencer dut (
    .clk_i(clk), .reset(rst_n), .start_i(start_i), .num_i(num_i), .abort_i(abort_i),
    .idx_o(idx_o), .entry_i(entry_i), .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i),
    .ad_o(ad_o), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
`ifdef RTC_SEQ_READBACK_EN
    , .mismatch_o(mismatch_o), .err_idx_o(err_idx_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs_n, wr_n, rd_n, oe, ad;
    logic [7:0] bus;
    logic       busy, done, aborted, rv;
    logic [7:0] rdata;
    logic [3:0] idx;
  } obs_t;

  typedef struct {
    int   tst;
    int   cyc;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rv_cnt = 0;

  function automatic obs_t get_obs();
    obs_t o;
    o = {cs_n, wr_n, rd_n, bus_oe, ad_o, bus_o, busy_o, done_o, aborted_o, rd_valid_o, rd_data_o, idx_o};
    return o;
  endfunction

  function automatic void add(input int t, input int c, input logic cs, wr, rd, oe, ad,
                              input logic [7:0] bus, input logic busy, done, rv,
                              input logic [7:0] rdata, input logic [3:0] idx);
    vec_t v;
    v.tst = t;
    v.cyc = c;
    v.exp = {cs, wr, rd, oe, ad, bus, busy, done, 1'b0, rv, rdata, idx};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start_i = 1'b1;
    num_i   = (IDX_W+1)'(n);
    cyc();
    start_i = 1'b0;
  endtask

  task automatic load_wr();
    tbl[0] = {1'b0, 8'h02, 8'h10};
    tbl[1] = {1'b0, 8'h02, 8'h00};
    tbl[2] = {1'b0, 8'h10, 8'hD2};
  endtask

  // Bus value only matters while the DUT drives it.
  task automatic run_vec(input int tst, input int n, input int last);
    obs_t got, exp;
    pulse_start(n);
    for (int c = 1; c <= last; c++) begin
      if (rd_valid_o) rv_cnt++;
      foreach (vecs[i]) begin
        if (vecs[i].tst == tst && vecs[i].cyc == c) begin
          got = get_obs();
          exp = vecs[i].exp;
          if (!exp.oe) begin
            got.bus = '0;
            exp.bus = '0;
          end
          chk($sformatf("seq%0d_cyc%0d", tst, c), 64'(got), 64'(exp));
        end
      end
      cyc();
    end
  endtask

  task automatic wait_done(input int c0, output int at);
    int c;
    c = c0;
    while (!done_o && c < 400) begin
      cyc();
      c++;
    end
    at = done_o ? c : -1;
  endtask

  obs_t rst_exp;
  int   at, dcnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // write sequence, entries 02:10, 02:00, 10:D2
    add(2,  1, 0,0,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd0);
    add(2,  7, 0,0,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd0);
    add(2,  8, 1,1,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd0);
    add(2, 14, 1,1,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd0);
    add(2, 15, 0,0,1,1,1, 8'h10, 1,0,0, 8'h00, 4'd0);
    add(2, 21, 0,0,1,1,1, 8'h10, 1,0,0, 8'h00, 4'd0);
    add(2, 22, 1,1,1,0,1, 8'h00, 1,0,0, 8'h00, 4'd0);
    add(2, 29, 0,0,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd1);
    add(2, 36, 1,1,1,1,0, 8'h02, 1,0,0, 8'h00, 4'd1);
    add(2, 43, 0,0,1,1,1, 8'h00, 1,0,0, 8'h00, 4'd1);
    add(2, 57, 0,0,1,1,0, 8'h10, 1,0,0, 8'h00, 4'd2);
    add(2, 71, 0,0,1,1,1, 8'hD2, 1,0,0, 8'h00, 4'd2);
    add(2, 77, 0,0,1,1,1, 8'hD2, 1,0,0, 8'h00, 4'd2);
    add(2, 78, 1,1,1,0,1, 8'h00, 1,0,0, 8'h00, 4'd2);
    add(2, 84, 1,1,1,0,1, 8'h00, 1,0,0, 8'h00, 4'd2);
    add(2, 85, 1,1,1,0,0, 8'h00, 1,1,0, 8'h00, 4'd0);
    add(2, 86, 1,1,1,0,0, 8'h00, 0,0,0, 8'h00, 4'd0);
    // single read entry at address 21, bus returns 3A
    add(3,  1, 0,0,1,1,0, 8'h21, 1,0,0, 8'h00, 4'd0);
    add(3, 14, 1,1,1,1,0, 8'h21, 1,0,0, 8'h00, 4'd0);
    add(3, 15, 0,1,0,0,1, 8'h00, 1,0,0, 8'h00, 4'd0);
    add(3, 21, 0,1,0,0,1, 8'h00, 1,0,0, 8'h00, 4'd0);
    add(3, 22, 1,1,1,0,1, 8'h00, 1,0,1, 8'h3A, 4'd0);
    add(3, 23, 1,1,1,0,1, 8'h00, 1,0,0, 8'h3A, 4'd0);
    add(3, 28, 1,1,1,0,1, 8'h00, 1,0,0, 8'h3A, 4'd0);
    add(3, 29, 1,1,1,0,0, 8'h00, 1,1,0, 8'h3A, 4'd0);
    add(3, 30, 1,1,1,0,0, 8'h00, 0,0,0, 8'h3A, 4'd0);

    rst_exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; num_i = '0; rb_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", 64'(get_obs()), 64'(rst_exp));
    rst_n = 1'b1;
    cyc();

    // reset asserted in the middle of an address strobe
    load_wr();
    pulse_start(3);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_release_strobes", {61'd0, cs_n, wr_n, bus_oe}, 64'b110);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_reset_idle", 64'(get_obs()), 64'(rst_exp));

`ifndef RTC_SEQ_READBACK_EN
    run_vec(2, 3, 86);
`endif

    tbl[0] = {1'b1, 8'h21, 8'h00};
    rv_cnt = 0;
    run_vec(3, 1, 30);
    chk("read_valid_pulses", 64'(rv_cnt), 64'd1);

    // empty table: finish immediately, no strobes
    cyc();
    pulse_start(0);
    chk("num0_cycle1", {58'd0, done_o, busy_o, cs_n, wr_n, rd_n, bus_oe}, 64'b111110);
    cyc();
    chk("num0_cycle2", {58'd0, done_o, busy_o, cs_n, wr_n, rd_n, bus_oe}, 64'b001110);

    // start while busy must not restart or change the count
    load_wr();
    pulse_start(3);
    repeat (4) cyc();
    start_i = 1'b1;
    num_i   = 5'd1;
    cyc();
    start_i = 1'b0;
    wait_done(6, at);
    chk("busy_start_done_cycle", 64'(at), 64'(1 + 3 * WR_ENTRY));
    cyc();
    chk("busy_start_idle_after", {63'd0, busy_o}, 64'd0);

`ifndef RTC_SEQ_READBACK_EN
    // abort on third data strobe cycle of entry 1
    cyc();
    pulse_start(3);
    repeat (44) cyc();
    chk("abort_pre_state", {57'd0, idx_o, cs_n, wr_n, ad_o}, {57'd0, 4'd1, 3'b001});
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("abort_next_cycle", {57'd0, cs_n, wr_n, rd_n, bus_oe, aborted_o, done_o, busy_o},
        64'b1110100);
    chk("abort_idx_not_advanced", 64'(idx_o), 64'd0);
    dcnt = 0;
    cyc();
    chk("abort_pulse_single", {63'd0, aborted_o}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (done_o) dcnt++;
      cyc();
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    pulse_start(3);
    wait_done(1, at);
    chk("restart_after_abort_done_cycle", 64'(at), 64'd85);
    cyc();
`endif

`ifdef RTC_SEQ_READBACK_EN
    // readback with entry 2 read back corrupted
    cyc();
    rb_mode = 1'b1;
    load_wr();
    pulse_start(3);
    chk("rb_mismatch_clear_on_start", {63'd0, mismatch_o}, 64'd0);
    wait_done(1, at);
    chk("rb_done_cycle", 64'(at), 64'(1 + 3 * WR_ENTRY));
    chk("rb_mismatch_set", {59'd0, mismatch_o, err_idx_o}, {59'd0, 1'b1, 4'd2});
    cyc();
    pulse_start(1);
    chk("rb_mismatch_cleared", {63'd0, mismatch_o}, 64'd0);
    wait_done(1, at);
    chk("rb_clean_entry_no_mismatch", {63'd0, mismatch_o}, 64'd0);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
